// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer
// Sequences a multi-block AES command over the engine and buffer memory.
// Accepts one command (mode, base word address, block count). It issues the engine control
// word once per 128-bit block and advances the block address by 4 words after each block.
// It also reports progress and sticky done/error status. A per-block watchdog and a software
// abort are included.
//
// Ports:
//   clk_in, rst_in                 clock, asynchronous active-low reset
//   cmd_valid_in / cmd_ready_out   command handshake (ready only in IDLE)
//   cmd_decrypt_in                 1 = decrypt, 0 = encrypt
//   cmd_base_addr_in               first word address of the first block
//   cmd_num_blocks_in              number of blocks to process
//   abort_in                       abort the running command
//   clear_in                       clear done/err/err_code
//   aes_ctrl_out                   {valid_result, decrypt, encrypt} to the engine
//   aes_blk_addr_out               word address of the current block
//   aes_complete_in                engine single-cycle block-done pulse
//   busy_out, done_out, err_out    status; done/err are sticky
//   err_code_out                   00 none, 01 range, 10 timeout, 11 abort
//   blocks_done_out                blocks completed in the current/last command
module aes_block_sequencer #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned NUM_W          = 9,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_out,
    input  logic              cmd_decrypt_in,
    input  logic [ADDR_W-1:0] cmd_base_addr_in,
    input  logic [NUM_W-1:0]  cmd_num_blocks_in,
    input  logic              abort_in,
    input  logic              clear_in,
    output logic [2:0]        aes_ctrl_out,
    output logic [ADDR_W-1:0] aes_blk_addr_out,
    input  logic              aes_complete_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic [1:0]        err_code_out,
    output logic [NUM_W-1:0]  blocks_done_out
);

    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SUM_W  = ADDR_W + NUM_W + 2;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrRange   = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;
    localparam logic [1:0] ErrAbort   = 2'b11;

    localparam logic [2:0] CtrlOff    = 3'b000;
    localparam logic [2:0] CtrlResult = 3'b100;

    typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

    state_e              state_q, state_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]   blk_addr_q, blk_addr_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [NUM_W-1:0]    blocks_done_q, blocks_done_d;
    logic                decrypt_q, decrypt_d;
    logic [NUM_W-1:0]    num_q, num_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;

    // End address is computed wide enough that it can never wrap.
    logic [SUM_W-1:0]    end_addr;
    logic [SUM_W-1:0]    addr_limit;
    logic                range_err;
    logic [NUM_W-1:0]    blocks_inc;

    assign end_addr   = SUM_W'(cmd_base_addr_in) + (SUM_W'(cmd_num_blocks_in) << 2);
    assign addr_limit = SUM_W'(1) << ADDR_W;
    assign range_err  = (cmd_base_addr_in[1:0] != 2'b00) || (end_addr > addr_limit);
    assign blocks_inc = blocks_done_q + NUM_W'(1);

    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_q;
        blk_addr_d    = blk_addr_q;
        done_d        = done_q;
        err_d         = err_q;
        err_code_d    = err_code_q;
        blocks_done_d = blocks_done_q;
        decrypt_d     = decrypt_q;
        num_d         = num_q;
        wdog_d        = wdog_q;

        // Status updates below are assigned later, so they override a same-cycle clear.
        if (clear_in) begin
            done_d     = 1'b0;
            err_d      = 1'b0;
            err_code_d = ErrNone;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_in) begin
                    done_d        = 1'b0;
                    err_d         = 1'b0;
                    err_code_d    = ErrNone;
                    blocks_done_d = '0;
                    decrypt_d     = cmd_decrypt_in;
                    num_d         = cmd_num_blocks_in;
                    if (range_err) begin
                        done_d     = 1'b1;
                        err_d      = 1'b1;
                        err_code_d = ErrRange;
                        ctrl_d     = CtrlOff;
                    end else if (cmd_num_blocks_in == '0) begin
                        done_d = 1'b1;
                        ctrl_d = CtrlOff;
                    end else begin
                        state_d    = StRun;
                        blk_addr_d = cmd_base_addr_in;
                        ctrl_d     = {1'b0, cmd_decrypt_in, ~cmd_decrypt_in};
                        wdog_d     = '0;
                    end
                end
            end

            StRun: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (aes_complete_in) begin
                    blocks_done_d = blocks_inc;
                end
                if (abort_in) begin
                    state_d    = StIdle;
                    ctrl_d     = CtrlOff;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ErrAbort;
                end else if (aes_complete_in) begin
                    if (blocks_inc == num_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        ctrl_d  = CtrlResult;
                    end else begin
                        // One GAP cycle drops the start bits so the engine sees a new edge.
                        state_d    = StGap;
                        ctrl_d     = CtrlResult;
                        blk_addr_d = blk_addr_q + ADDR_W'(4);
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d    = StIdle;
                    ctrl_d     = CtrlOff;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                end
            end

            StGap: begin
                if (abort_in) begin
                    state_d    = StIdle;
                    ctrl_d     = CtrlOff;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ErrAbort;
                end else begin
                    state_d = StRun;
                    ctrl_d  = {1'b0, decrypt_q, ~decrypt_q};
                    wdog_d  = '0;
                end
            end

            default: begin
                state_d = StIdle;
                ctrl_d  = CtrlOff;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= StIdle;
            ctrl_q        <= CtrlOff;
            blk_addr_q    <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ErrNone;
            blocks_done_q <= '0;
            decrypt_q     <= 1'b0;
            num_q         <= '0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            blk_addr_q    <= blk_addr_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            blocks_done_q <= blocks_done_d;
            decrypt_q     <= decrypt_d;
            num_q         <= num_d;
            wdog_q        <= wdog_d;
        end
    end

    assign cmd_ready_out    = (state_q == StIdle);
    assign busy_out         = (state_q != StIdle);
    assign aes_ctrl_out     = ctrl_q;
    assign aes_blk_addr_out = blk_addr_q;
    assign done_out         = done_q;
    assign err_out          = err_q;
    assign err_code_out     = err_code_q;
    assign blocks_done_out  = blocks_done_q;

endmodule
